// File: rtl/avr_tx_pkg.sv
// Shared FSM encoding and frame-length constants for the AVR UART transmitter.
// Defining AVR_TX_PARITY_EN adds a PARITY state and one even-parity bit per frame.
package avr_tx_pkg;
  localparam int DATA_BITS = 8;

`ifdef AVR_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  // start + data + optional parity + stop
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;
endpackage

// File: rtl/avr_tx_fifo.sv
// Transmit byte FIFO: power-of-two depth, wrapping pointers, head visible combinationally.
// A push is refused while full even if a pop happens on the same edge.
module avr_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]          count_reg, count_next;
  logic [DEPTH-1:0][7:0]   entries;
  logic                    push_ok, pop_ok;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [7:0] entry_reg;
    always_ff @(posedge clk) begin
      if (push_ok && wr_ptr_reg == PTR_W'(gi))
        entry_reg <= wdata;
    end
    assign entries[gi] = entry_reg;
  end

  assign rdata = entries[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/avr_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter feeding an AVR Rx pin, throttled by the AVR's busy flag.
// Optional even parity bit when AVR_TX_PARITY_EN is defined.
module avr_uart_tx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          avr_rx_busy,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  import avr_tx_pkg::*;

  localparam logic [15:0] TIMER_LOAD = 16'(CLK_PER_BIT - 1);

  tx_state_t   state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;
  logic        sync1_reg, sync2_reg;
  logic        blk;
  logic        pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
`ifdef AVR_TX_PARITY_EN
  logic        parity_reg, parity_next;
`endif

  avr_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign tx       = tx_reg;
  assign busy     = (state_reg != IDLE) || !fifo_empty;

  // Reset to "blocked" so nothing starts until the pin has been seen low twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= avr_rx_busy;
      sync2_reg <= sync1_reg;
    end
  end
  assign blk = sync2_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
`ifdef AVR_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !blk) begin
          pop        = 1'b1;
          shift_next = fifo_rdata;
          timer_next = TIMER_LOAD;
          idx_next   = '0;
          state_next = START;
`ifdef AVR_TX_PARITY_EN
          parity_next = ^fifo_rdata;
`endif
        end
      end
      START: begin
        if (timer_reg == '0) begin
          timer_next = TIMER_LOAD;
          state_next = DATA;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
      DATA: begin
        if (timer_reg == '0) begin
          timer_next = TIMER_LOAD;
          shift_next = {1'b0, shift_reg[7:1]};
          if (idx_reg == 3'(DATA_BITS - 1)) begin
            idx_next = '0;
`ifdef AVR_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
`ifdef AVR_TX_PARITY_EN
      PARITY: begin
        if (timer_reg == '0) begin
          timer_next = TIMER_LOAD;
          state_next = STOP;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
`endif
      STOP: begin
        if (timer_reg == '0) begin
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx follows the state one edge later, so line timing tracks the bit timer exactly.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
`ifdef AVR_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
`ifdef AVR_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
`ifdef AVR_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end
endmodule

// File: tb/tb_avr_uart_tx.sv
// Directed bench for avr_uart_tx with CLK_PER_BIT=4, FIFO_DEPTH=4.
// Build with AVR_TX_PARITY_EN defined to exercise the parity frame as well.
module tb_avr_uart_tx;
  localparam int CPB = 4;
`ifdef AVR_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int SPACING = FB * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       in_valid;
  logic       in_ready;
  logic       avr_rx_busy;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic busy_pen;

  avr_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .avr_rx_busy (avr_rx_busy),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fall(input string tag, input int max, output int at);
    int n = 0;
    while (tx !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    if (tx !== 1'b0) check({tag, " fall timeout"}, 32'(tx), 32'd0);
    at = cyc;
  endtask

  // Starts on the first low sample of a frame; returns on its last stop-bit sample.
  task automatic check_frame(input string tag, input logic [7:0] b, input int raise_at);
    logic [FB-1:0] bits;
    logic [3:0]    s;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef AVR_TX_PARITY_EN
    bits[9] = ^b;
`endif
    bits[FB-1] = 1'b1;
    for (int j = 0; j < FB; j++) begin
      for (int m = 0; m < CPB; m++) begin
        s[m] = tx;
        if (j == FB-1 && m == CPB-2) busy_pen = busy;
        if (j*CPB + m == raise_at) avr_rx_busy = 1'b1;
        if (!(j == FB-1 && m == CPB-1)) tick();
      end
      check($sformatf("%s bit%0d", tag, j), 32'(s), 32'({4{bits[j]}}));
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    data = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle_watch(input string tag, input int n);
    logic tx_min = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      tx_min &= tx;
    end
    check({tag, " tx stays idle"}, 32'(tx_min), 32'd1);
  endtask

  initial begin
    int at, prev, c, k;
    logic [7:0] exp_bytes [4];

    rst = 1'b1; data = 8'h00; in_valid = 1'b0; avr_rx_busy = 1'b0;
    #1;
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();

    // Single byte into an idle, unblocked transmitter
    push_byte(8'h55);
    k = cyc;
    check("0x55 count after accept", 32'(fifo_count), 32'd1);
    wait_fall("0x55", 10, at);
    check("0x55 fall latency", 32'(at - k), 32'd2);
    check_frame("0x55", 8'h55, -1);
    check("0x55 busy before drop", 32'(busy_pen), 32'd1);
    check("0x55 busy dropped", 32'(busy), 32'd0);
    check("0x55 busy drop time", 32'(cyc - k), 32'(FB*CPB + 1));

    // Fill while blocked; the fifth write is refused
    avr_rx_busy = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      data = 8'(i + 1);
      in_valid = 1'b1;
      check($sformatf("blocked write %0d in_ready", i+1), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    check("blocked fifo_count", 32'(fifo_count), 32'd4);
    check("blocked busy", 32'(busy), 32'd1);
    idle_watch("blocked", 12);
    avr_rx_busy = 1'b0;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_fall($sformatf("queued %0d", i+1), 60, at);
      if (i == 0) check("unblock latency", 32'(at - c), 32'd4);
      else        check($sformatf("spacing %0d", i+1), 32'(at - prev), 32'(SPACING));
      check_frame($sformatf("queued 0x%02h", i+1), 8'(i+1), -1);
      prev = at;
    end
    check("queue drained count", 32'(fifo_count), 32'd0);
    check("queue drained busy", 32'(busy), 32'd0);

    // Busy raised mid-frame: current frame completes, next one waits
    push_byte(8'hA3);
    push_byte(8'h3C);
    wait_fall("0xA3", 10, at);
    check_frame("0xA3", 8'hA3, 4*CPB + 1);
    idle_watch("held", 20);
    check("held fifo_count", 32'(fifo_count), 32'd1);
    avr_rx_busy = 1'b0;
    c = cyc;
    wait_fall("0x3C", 20, at);
    check("release latency", 32'(at - c), 32'd4);
    check_frame("0x3C", 8'h3C, -1);

    // Full FIFO with a simultaneous pop: write refused, nothing lost
    avr_rx_busy = 1'b1;
    tick(); tick(); tick();
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) push_byte(exp_bytes[i]);
    avr_rx_busy = 1'b0;
    tick(); tick();
    data = 8'h99;
    in_valid = 1'b1;
    check("full in_ready", 32'(in_ready), 32'd0);
    check("full count before pop", 32'(fifo_count), 32'd4);
    tick();
    in_valid = 1'b0;
    check("full count after pop", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 4; i++) begin
      wait_fall($sformatf("full %0d", i), 60, at);
      check_frame($sformatf("full 0x%02h", exp_bytes[i]), exp_bytes[i], -1);
    end
    idle_watch("no extra byte", 50);
    check("full drained busy", 32'(busy), 32'd0);

    // Reset during DATA bit 5 with two bytes still queued
    push_byte(8'hF0);
    push_byte(8'h0F);
    push_byte(8'hAA);
    wait_fall("rst frame", 10, at);
    for (int i = 0; i < 6*CPB + 1; i++) tick();
    check("pre-reset count", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    #1;
    check("mid-frame rst tx", 32'(tx), 32'd1);
    check("mid-frame rst count", 32'(fifo_count), 32'd0);
    check("mid-frame rst busy", 32'(busy), 32'd0);
    check("mid-frame rst in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    idle_watch("post-reset", 50);
    check("post-reset busy", 32'(busy), 32'd0);

    // After release, a byte waits until blk has been sampled low twice
    rst = 1'b1;
    tick(); tick();
    k = cyc;
    rst = 1'b0;
    data = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_fall("post-release", 10, at);
    check("post-release latency", 32'(at - k), 32'd4);
    check_frame("0x5A", 8'h5A, -1);

`ifdef AVR_TX_PARITY_EN
    push_byte(8'h07);
    k = cyc;
    wait_fall("par 0x07", 10, at);
    check_frame("par 0x07", 8'h07, -1);
    check("par 0x07 frame length", 32'(cyc - k - 1), 32'd44);
    push_byte(8'h03);
    wait_fall("par 0x03", 10, at);
    check_frame("par 0x03", 8'h03, -1);
`endif

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
